// File: rtl/framebuf_bank_sched.sv
// framebuf_bank_sched: triple-buffer bank scheduler between a camera writer and
// a display reader sharing one frame memory. Banks swap only on frame-boundary
// pulses, so the reader never scans a frame that is still being written.
// Optional build macro FB_STATS_EN adds saturating drop/repeat statistics
// counters; without it o_drop_cnt and o_repeat_cnt are tied to zero.
`timescale 1ns/1ps
module framebuf_bank_sched #(
  parameter int FRAME_WORDS    = 307200,
  parameter int ADDR_W         = 20,
  parameter int STARTUP_FRAMES = 2,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_frame_done,
  input  logic              i_rd_frame_start,
  input  logic              i_freeze,
  output logic [1:0]        o_wr_bank,
  output logic [1:0]        o_rd_bank,
  output logic [ADDR_W-1:0] o_wr_base,
  output logic [ADDR_W-1:0] o_rd_base,
  output logic              o_rd_valid,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic [CNT_W-1:0]  o_repeat_cnt
);

  localparam int                SC_W     = $clog2(STARTUP_FRAMES + 1);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(STARTUP_FRAMES - 1);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BASE2    = ADDR_W'(2 * FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   startup_cnt_q, startup_cnt_d;
  logic [1:0]        wr_q, wr_d;
  logic [1:0]        rd_q, rd_d;
  logic [1:0]        spare_q, spare_d;
  logic              fresh_q, fresh_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;

  logic              wr_swap;
  logic              rd_swap;

  // Base offset of a bank; constants avoid a runtime multiplier.
  function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] b);
    case (b)
      2'd1:    bank_base = BASE1;
      2'd2:    bank_base = BASE2;
      default: bank_base = '0;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: startup discards frames, armed waits for the first real swap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STARTUP: if (i_wr_frame_done && (startup_cnt_q == SC_LAST)) state_d = ST_ARMED;
      ST_ARMED:   if (rd_swap) state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_STARTUP;
    endcase
  end

  // FSM outputs: which swaps the current state allows this cycle.
  // A same-cycle write completion guarantees a newer frame, so fresh is not needed then.
  always_comb begin
    wr_swap = i_wr_frame_done;
    rd_swap = 1'b0;
    if ((state_q != ST_STARTUP) && i_rd_frame_start && !i_freeze) begin
      rd_swap = i_wr_frame_done | fresh_q;
    end
  end

  // Bank permutation, fresh flag, startup count, valid and base next values.
  always_comb begin
    wr_d          = wr_q;
    rd_d          = rd_q;
    spare_d       = spare_q;
    fresh_d       = fresh_q;
    startup_cnt_d = startup_cnt_q;
    if (wr_swap && rd_swap) begin
      // Write handled first: the just-finished frame goes straight to the reader.
      rd_d    = wr_q;
      wr_d    = spare_q;
      spare_d = rd_q;
      fresh_d = 1'b0;
    end else if (wr_swap) begin
      wr_d    = spare_q;
      spare_d = wr_q;
      fresh_d = 1'b1;
    end else if (rd_swap) begin
      rd_d    = spare_q;
      spare_d = rd_q;
      fresh_d = 1'b0;
    end
    if ((state_q == ST_STARTUP) && i_wr_frame_done) begin
      startup_cnt_d = startup_cnt_q + 1'b1;
    end
    rd_valid_d = rd_valid_q | (state_d == ST_RUN);
    wr_base_d  = bank_base(wr_d);
    rd_base_d  = bank_base(rd_d);
  end

  // Bank state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      startup_cnt_q <= '0;
      wr_q          <= 2'd0;
      rd_q          <= 2'd1;
      spare_q       <= 2'd2;
      fresh_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_base_q     <= '0;
      rd_base_q     <= BASE1;
    end else begin
      startup_cnt_q <= startup_cnt_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      spare_q       <= spare_d;
      fresh_q       <= fresh_d;
      rd_valid_q    <= rd_valid_d;
      wr_base_q     <= wr_base_d;
      rd_base_q     <= rd_base_d;
    end
  end

  assign o_wr_bank  = wr_q;
  assign o_rd_bank  = rd_q;
  assign o_wr_base  = wr_base_q;
  assign o_rd_base  = rd_base_q;
  assign o_rd_valid = rd_valid_q;

`ifdef FB_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] repeat_cnt_q, repeat_cnt_d;
  logic             in_run;
  logic             drop_evt;
  logic             repeat_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Statistics events: a fresh frame overwritten unseen, or a reader frame re-shown.
  always_comb begin
    in_run       = (state_q == ST_RUN);
    drop_evt     = in_run && i_wr_frame_done && fresh_q && !rd_swap;
    repeat_evt   = in_run && i_rd_frame_start && !rd_swap;
    drop_cnt_d   = drop_evt   ? sat_inc(drop_cnt_q)   : drop_cnt_q;
    repeat_cnt_d = repeat_evt ? sat_inc(repeat_cnt_q) : repeat_cnt_q;
  end

  // Statistics counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign o_drop_cnt   = drop_cnt_q;
  assign o_repeat_cnt = repeat_cnt_q;
`else
  assign o_drop_cnt   = '0;
  assign o_repeat_cnt = '0;
`endif

endmodule
